// File: rtl/fb_pkg.sv
// Shared types and default image constants for the frame-buffer port arbiter.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;

  localparam int IMG_WIDTH  = 200;
  localparam int IMG_HEIGHT = 138;
  localparam int MEM_WORDS  = IMG_WIDTH * IMG_HEIGHT;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Single-port BSRAM bus between the arbiter (master) and the Gowin_SP RAM (slave).
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              RAM_CE;
  logic              RAM_WRE;
  logic [ADDR_W-1:0] RAM_AD;
  logic [DATA_W-1:0] RAM_DIN;
  logic [DATA_W-1:0] RAM_DOUT;

  modport master (
    output RAM_CE, RAM_WRE, RAM_AD, RAM_DIN,
    input  RAM_DOUT
  );

  modport slave (
    input  RAM_CE, RAM_WRE, RAM_AD, RAM_DIN,
    output RAM_DOUT
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous {addr,data} write queue with registered full/empty/count flags.
module fb_wr_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 31,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates the image BSRAM between display reads, queued pixel writes and a clear engine.
// Optional statistics outputs are enabled with FB_ARB_STATS_EN.
module fb_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int MEM_WORDS  = fb_pkg::MEM_WORDS,
  parameter int FIFO_DEPTH = 8,
  parameter int RAM_LAT    = 1
) (
  input  logic                 PixelClk,
  input  logic                 RST,
  input  logic                 RD_REQ,
  input  logic [ADDR_W-1:0]    RD_ADDR,
  output logic [DATA_W-1:0]    RD_DATA,
  output logic                 RD_VALID,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  input  logic [ADDR_W-1:0]    WR_ADDR,
  input  logic [DATA_W-1:0]    WR_DATA,
  input  logic                 CLR_START,
  input  logic [DATA_W-1:0]    CLR_COLOR,
  output logic                 CLR_BUSY,
  output logic                 CLR_DONE,
  fb_port_arbiter_if.master    ram
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]                    WR_STALL_CNT,
  output logic [$clog2(FIFO_DEPTH):0]    FIFO_HWM
`endif
);
  import fb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MEM_WORDS - 1);

  // IDLE: port free for queued writes | DRAIN: flushing queue before clear | CLEAR: filling buffer
  fb_state_t state;
  fb_state_t state_nxt;

  logic [ADDR_W-1:0]  clr_addr;
  logic [DATA_W-1:0]  clr_color;
  logic               clr_done_q;
  logic               clr_grant;
  logic               clr_last_wr;
  logic               wr_ready;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [EW-1:0]      fifo_head;
  logic [RAM_LAT-1:0] rd_pipe;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_wr_fifo (
    .clk   (PixelClk),
    .rst   (RST),
    .push  (fifo_push),
    .din   ({WR_ADDR, WR_DATA}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      state      <= IDLE;
      clr_addr   <= '0;
      clr_color  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_done_q <= clr_last_wr;
      if (state == IDLE && CLR_START) clr_color <= CLR_COLOR;
      if (clr_grant) clr_addr <= clr_last_wr ? '0 : clr_addr + ADDR_W'(1);
    end
  end

  // A push landing on the cycle the queue reads empty keeps DRAIN alive one more cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (CLR_START) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !fifo_push) state_nxt = CLEAR;
      CLEAR:   if (clr_last_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready    = !RST && !fifo_full && (state != CLEAR);
    fifo_push   = WR_VALID && wr_ready;
    clr_grant   = !RST && !RD_REQ && (state == CLEAR);
    clr_last_wr = clr_grant && (clr_addr == CLR_LAST);
    fifo_pop    = !RST && !RD_REQ && (state != CLEAR) && !fifo_empty;

    ram.RAM_CE  = 1'b1;
    ram.RAM_WRE = clr_grant || fifo_pop;
    ram.RAM_AD  = fifo_head[EW-1:DATA_W];
    ram.RAM_DIN = fifo_head[DATA_W-1:0];
    if (RD_REQ) begin
      ram.RAM_AD = RD_ADDR;
    end else if (state == CLEAR) begin
      ram.RAM_AD  = clr_addr;
      ram.RAM_DIN = clr_color;
    end

    WR_READY = wr_ready;
    CLR_BUSY = (state != IDLE);
    CLR_DONE = clr_done_q;
  end

  always_ff @(posedge PixelClk) begin
    if (RST) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= RD_REQ;
      for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign RD_VALID = rd_pipe[RAM_LAT-1];
  assign RD_DATA  = ram.RAM_DOUT;

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      WR_STALL_CNT <= '0;
      FIFO_HWM     <= '0;
    end else begin
      if (WR_VALID && !wr_ready && WR_STALL_CNT != 16'hFFFF)
        WR_STALL_CNT <= WR_STALL_CNT + 16'd1;
      if (fifo_count > FIFO_HWM) FIFO_HWM <= fifo_count;
    end
  end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a 2-cycle RAM model; honours FB_ARB_STATS_EN.
module tb_fb_port_arbiter;
  localparam int AW  = 15;
  localparam int DW  = 16;
  localparam int MW  = 27600;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          RD_REQ = 1'b0;
  logic [AW-1:0] RD_ADDR = '0;
  logic [DW-1:0] RD_DATA;
  logic          RD_VALID;
  logic          WR_VALID = 1'b0;
  logic          WR_READY;
  logic [AW-1:0] WR_ADDR = '0;
  logic [DW-1:0] WR_DATA = '0;
  logic          CLR_START = 1'b0;
  logic [DW-1:0] CLR_COLOR = '0;
  logic          CLR_BUSY;
  logic          CLR_DONE;
`ifdef FB_ARB_STATS_EN
  logic [15:0]   WR_STALL_CNT;
  logic [3:0]    FIFO_HWM;
`endif

  fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  fb_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .FIFO_DEPTH(8), .RAM_LAT(LAT)
  ) dut (
    .PixelClk(clk), .RST(RST),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .CLR_START(CLR_START), .CLR_COLOR(CLR_COLOR), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE),
    .ram(ram_if)
`ifdef FB_ARB_STATS_EN
    , .WR_STALL_CNT(WR_STALL_CNT), .FIFO_HWM(FIFO_HWM)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: two-cycle read latency, output holds on write/idle cycles
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_s1;
  always @(posedge clk) begin
    if (ram_if.RAM_CE) begin
      if (ram_if.RAM_WRE) mem[ram_if.RAM_AD] <= ram_if.RAM_DIN;
      else                rd_s1 <= mem[ram_if.RAM_AD];
    end
    ram_if.RAM_DOUT <= rd_s1;
  end

  typedef struct {
    logic [AW+DW-1:0] aw;
    bit               fill;
    bit               last;
  } wr_t;
  typedef struct {
    int            due;
    bit            chk;
    logic [DW-1:0] exp;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t e_pop;
  rd_t r_pop;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_due = -1;
  int done_cnt = 0;
  int free_cnt = 0;
  bit fill_win = 0;
  bit rd_chk = 0;
  logic [DW-1:0] rd_exp = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RST) begin
      check("rst_wre", RAM_WRE_s(), 0);
      check("rst_ready", WR_READY, 0);
      wq.delete();
      rq.delete();
      fill_win = 0;
      done_due = -1;
    end else begin
      if (WR_VALID && WR_READY) wq.push_back('{{WR_ADDR, WR_DATA}, 1'b0, 1'b0});
      if (RD_REQ) begin
        check("rd_pri_wre", ram_if.RAM_WRE, 0);
        check("rd_addr", ram_if.RAM_AD, RD_ADDR);
        rq.push_back('{cyc + LAT, rd_chk, rd_exp});
      end
      e_pop = '{'0, 1'b0, 1'b0};
      if (ram_if.RAM_WRE) begin
        if (wq.size() == 0) begin
          check("wr_extra", ram_if.RAM_WRE, 0);
        end else begin
          e_pop = wq.pop_front();
          check("wr_seq", {ram_if.RAM_AD, ram_if.RAM_DIN}, e_pop.aw);
          if (e_pop.fill && !fill_win) begin
            fill_win = 1;
            free_cnt = 0;
          end
        end
      end
      if (fill_win) begin
        check("clr_wr_ready", WR_READY, 0);
        if (!RD_REQ) free_cnt++;
      end
      if (e_pop.last) begin
        check("clr_free_cycles", free_cnt, MW);
        fill_win = 0;
        done_due = cyc + 1;
      end
      if (RD_VALID) begin
        if (rq.size() == 0) begin
          check("rd_extra", RD_VALID, 0);
        end else begin
          r_pop = rq.pop_front();
          check("rd_lat", cyc, r_pop.due);
          if (r_pop.chk) check("rd_data", RD_DATA, r_pop.exp);
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        check("rd_missing", RD_VALID, 1);
        void'(rq.pop_front());
      end
    end
    check("clr_done", CLR_DONE, (cyc == done_due));
    if (CLR_DONE) done_cnt++;
  end

  function automatic logic RAM_WRE_s();
    return ram_if.RAM_WRE;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fills(input logic [DW-1:0] color);
    for (int a = 0; a < MW; a++) wq.push_back('{{AW'(a), color}, 1'b1, (a == MW - 1)});
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    step(); RD_REQ = 1; RD_ADDR = addr; rd_chk = 1; rd_exp = exp;
    step(); RD_REQ = 0; rd_chk = 0;
    step();
    step();
  endtask

  int acc;

  initial begin
    repeat (2) step();
    @(negedge clk);
    check("rst_rd_valid", RD_VALID, 0);
    check("rst_busy", CLR_BUSY, 0);
    check("rst_done", CLR_DONE, 0);

    // single write straight out of reset
    step(); RST = 0; WR_VALID = 1; WR_ADDR = 15'h0010; WR_DATA = 16'hF800;
    @(negedge clk);
    check("first_ready", WR_READY, 1);
    check("wr1_not_early", ram_if.RAM_WRE, 0);
    step(); WR_VALID = 0;
    @(negedge clk);
    check("wr1_wre", ram_if.RAM_WRE, 1);
    check("wr1_ad", ram_if.RAM_AD, 15'h0010);
    check("wr1_din", ram_if.RAM_DIN, 16'hF800);
    step();

    // read latency with RAM_LAT=2
    step(); RD_REQ = 1; RD_ADDR = 15'h0010; rd_chk = 1; rd_exp = 16'hF800;
    @(negedge clk); check("lat_t0", RD_VALID, 0);
    step(); RD_REQ = 0; rd_chk = 0;
    @(negedge clk); check("lat_t1", RD_VALID, 0);
    step();
    @(negedge clk); check("lat_t2", RD_VALID, 1); check("lat_data", RD_DATA, 16'hF800);
    step();
    @(negedge clk); check("lat_t3", RD_VALID, 0);

    // back-to-back reads
    step(); RD_REQ = 1; rd_chk = 1;
    repeat (3) step();
    RD_REQ = 0; rd_chk = 0;
    repeat (4) step();

    // read priority: 20-cycle read burst with writes offered throughout
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      RD_REQ = 1; RD_ADDR = 15'h0020; WR_VALID = 1;
      WR_ADDR = 15'h0100 + AW'(acc & 3); WR_DATA = 16'hA000 + DW'(acc);
      @(negedge clk);
      check("burst_ready", WR_READY, (acc < 8));
      if (WR_READY) acc++;
    end
    check("burst_accepts", acc, 8);
    step(); RD_REQ = 0; WR_VALID = 0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    check("burst_retired", wq.size(), 0);
`ifdef FB_ARB_STATS_EN
    #1;
    check("stall_cnt", WR_STALL_CNT, 12);
    check("fifo_hwm", FIFO_HWM, 8);
`endif
    do_read(15'h0100, 16'hA004);
    do_read(15'h0103, 16'hA007);

    // clear: 3 queued writes behind reads, then clear at 50% read duty
    step(); RD_REQ = 1; RD_ADDR = 15'h0; WR_VALID = 1; WR_ADDR = 15'h0200; WR_DATA = 16'h1111;
    step(); WR_ADDR = 15'h0201; WR_DATA = 16'h2222;
    step(); WR_ADDR = 15'h0202; WR_DATA = 16'h3333;
    step(); WR_VALID = 0; CLR_START = 1; CLR_COLOR = 16'h07E0;
    push_fills(16'h07E0);
    step(); CLR_START = 0; CLR_COLOR = 16'h0;
    @(negedge clk); check("clr_busy", CLR_BUSY, 1);
    for (int i = 0; i < 60000 && done_cnt == 0; i++) begin
      step();
      RD_REQ = i[0];
      CLR_START = (i == 1000);
      CLR_COLOR = (i == 1000) ? 16'hFFFF : 16'h0;
    end
    RD_REQ = 0; CLR_START = 0;
    check("clr_finished", done_cnt, 1);
    @(negedge clk); check("clr_idle", CLR_BUSY, 0);
    repeat (3) step();
    check("clr_done_once", done_cnt, 1);
    do_read(15'd0, 16'h07E0);
    do_read(15'd13799, 16'h07E0);
    do_read(15'd27599, 16'h07E0);

    // reset mid-drain: queued writes must vanish
    step(); RD_REQ = 1; WR_VALID = 1; WR_ADDR = 15'h0300; WR_DATA = 16'hBEEF;
    step(); WR_ADDR = 15'h0301;
    step(); WR_VALID = 0; CLR_START = 1; CLR_COLOR = 16'h0;
    step(); CLR_START = 0; RD_REQ = 0; RST = 1;
    @(negedge clk); check("drain_rst_ready", WR_READY, 0);
    step(); RST = 0;
    @(negedge clk); check("drain_rst_busy", CLR_BUSY, 0);
    repeat (10) step();
    do_read(15'h0300, 16'h07E0);

    // reset mid-clear
    step(); CLR_START = 1; CLR_COLOR = 16'h1234;
    push_fills(16'h1234);
    step(); CLR_START = 0;
    repeat (100) step();
    RST = 1;
    @(negedge clk); check("clr_rst_wre", ram_if.RAM_WRE, 0);
    step(); RST = 0;
    @(negedge clk);
    check("clr_rst_busy", CLR_BUSY, 0);
    check("clr_rst_ready", WR_READY, 1);
    repeat (20) step();
    check("clr_rst_no_done", done_cnt, 1);
`ifdef FB_ARB_STATS_EN
    check("rst_stall_cnt", WR_STALL_CNT, 0);
    check("rst_fifo_hwm", FIFO_HWM, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single-port image BSRAM (RGB565, 16-bit words) between the LCD scan-out read path and a pixel-write source such as an image loader. It also provides a whole-buffer clear engine. Display reads always win the port; writes are queued in a small FIFO and retired on cycles with no read. The block sits between the LCD timing/addressing logic and the `Gowin_SP` instance.

## Interface
Parameters:
- `ADDR_W`, 15: RAM address width.
- `DATA_W`, 16: RAM word width (RGB565).
- `MEM_WORDS`, 27600: words covered by the clear engine (200×138 image).
- `FIFO_DEPTH`, 8: write-queue entries; must be a power of 2 and ≥2.
- `RAM_LAT`, 1: RAM read latency in cycles; legal values 1 or 2.

Ports:
- `PixelClk`  in  1  sole clock; all logic on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RD_REQ`  in  1  display read request this cycle; always serviced.
- `RD_ADDR`  in  ADDR_W  display read address.
- `RD_DATA`  out  DATA_W  read data, direct from `RAM_DOUT`.
- `RD_VALID`  out  1  `RD_DATA` valid; delayed copy of a granted `RD_REQ`.
- `WR_VALID`  in  1  writer offers a word.
- `WR_READY`  out  1  queue accepts a word; a transfer occurs when `WR_VALID && WR_READY`.
- `WR_ADDR`  in  ADDR_W  write address.
- `WR_DATA`  in  DATA_W  write data.
- `CLR_START`  in  1  one-cycle pulse; starts a buffer clear.
- `CLR_COLOR`  in  DATA_W  fill value; sampled on the accepted `CLR_START`.
- `CLR_BUSY`  out  1  clear sequence in progress.
- `CLR_DONE`  out  1  one-cycle pulse when the clear finishes.
- `RAM_CE`  out  1  RAM enable.
- `RAM_WRE`  out  1  RAM write enable.
- `RAM_AD`  out  ADDR_W  RAM address.
- `RAM_DIN`  out  DATA_W  RAM write data.
- `RAM_DOUT`  in  DATA_W  RAM read data.

## Operation
- Port mux is combinational and evaluated each cycle, with this priority:
  1. `RD_REQ`: read of `RD_ADDR`.
  2. In CLEAR: write `CLR_COLOR` to the clear counter address.
  3. FIFO not empty: write the head entry, then pop it.
  4. Otherwise: idle (`RAM_WRE`=0).
- `RAM_CE` is tied to 1. The RAM holds its last `RAM_DOUT` on write and idle cycles.
- FIFO:
  - `WR_READY = !full && state != CLEAR`, using registered occupancy only.
  - A pop in the same cycle does not make room until the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Writes to the same address retire in acceptance order.
- FSM states and transitions:
  - IDLE → DRAIN on `CLR_START`.
  - DRAIN: waits for the FIFO to empty; `WR_READY` behaves normally, but new pushes extend DRAIN. DRAIN → CLEAR when the FIFO is empty.
  - CLEAR: the address counter starts at 0 and advances only on cycles it owns the port. After writing `MEM_WORDS-1` it goes to IDLE and pulses `CLR_DONE` for one cycle.
  - `CLR_BUSY` = (state != IDLE).
  - `CLR_START` while busy is ignored.
- Arithmetic: the clear counter is ADDR_W bits wide and never wraps. `MEM_WORDS` ≤ 2^ADDR_W is a design rule. Occupancy is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - `WR_READY`=0 and `RAM_WRE`=0 while `RST`=1.
  - `RD_VALID`=0, `CLR_BUSY`=0, `CLR_DONE`=0.
  - FIFO empty, FSM in IDLE, clear counter 0.
  - The first cycle after `RST` deasserts has `WR_READY`=1.
- Reset mid-clear or mid-drain: FIFO contents are discarded; no `CLR_DONE` is issued.
- Read latency: `RD_VALID` rises exactly `RAM_LAT` cycles after a granted `RD_REQ`. Back-to-back reads give back-to-back valids.
- Write latency: minimum 1 cycle from acceptance to the RAM write (entry registered, written the next free cycle). It is unbounded while `RD_REQ` stays high.
- Clear duration: `MEM_WORDS` port-free cycles after DRAIN completes.

## Configuration
- `FB_ARB_STATS_EN` defined adds two outputs:
  - `WR_STALL_CNT` (16): saturating count of cycles with `WR_VALID && !WR_READY`.
  - `FIFO_HWM` (log2(FIFO_DEPTH)+1): peak FIFO occupancy.
  - Both clear on `RST` only.
- Without the macro, these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package `fb_pkg`:
  - FSM state enum {IDLE, DRAIN, CLEAR}.
  - Default image constants (IMG_WIDTH=200, IMG_HEIGHT=138, MEM_WORDS).
  - RGB565 field widths.
- One sub-module, `fb_wr_fifo`: synchronous FIFO of {addr,data} with registered full/empty/count, parameterised by depth and width.
- The FSM, mux and latency shift register stay in the top level.

## Test plan
- Reset then single write: `WR_ADDR`=0x0010, `WR_DATA`=0xF800, `RD_REQ`=0 → the next cycle shows `RAM_WRE`=1, `RAM_AD`=0x0010, `RAM_DIN`=0xF800.
- Read priority: `RD_REQ` held high for 20 cycles with 8 writes offered → `WR_READY` drops after 8 accepts; no `RAM_WRE` during the burst; all 8 writes retire in order within 8 cycles after `RD_REQ` falls.
- Read latency: `RD_REQ` pulse at cycle t with `RAM_LAT`=2 → `RD_VALID`=1 only at t+2, and `RD_DATA` equals the stored word.
- Clear: 3 queued writes, then `CLR_START` with `CLR_COLOR`=0x07E0 → DRAIN writes the 3 words first, then 27600 fills; `CLR_DONE` pulses once; readback of addresses 0, 13799 and 27599 gives 0x07E0.
- Clear interleaved with reads (`RD_REQ` at 50% duty) → the clear takes exactly 27600 port-free cycles; `WR_READY`=0 throughout CLEAR; a second `CLR_START` while busy is ignored.
- Reset asserted mid-CLEAR → `CLR_BUSY`=0 the next cycle; no `CLR_DONE` pulse; FIFO empty; with `FB_ARB_STATS_EN`, `WR_STALL_CNT`=0.
